// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - Memory-stage data responder: RAM, GPIO and cycle counter
//
// Purpose:
//   Single-cycle data-side responder for an RV32I pipeline Memory stage.
//   Loads are combinational and return the contents as they stood before
//   any store in the same cycle. Stores commit on the rising clock edge.
//
// Parameters:
//   DEPTH_WORDS - RAM size in 32-bit words (power of two)
//   IO_BASE     - byte address of the I/O window (GPIO_OUT, GPIO_IN, CYCLE)
//
// Ports:
//   clk         - clock, all state updates on the rising edge
//   reset       - asynchronous active-low reset
//   MemWriteM   - store request this cycle
//   Funct3M     - RV32I load/store width and sign code
//   ALUResultM  - byte address
//   WriteDataM  - store data, right-aligned
//   gpio_in     - external input pins
//   ReadDataM   - load data, sign/zero extended
//   gpio_out    - GPIO output register
//   MisalignM   - current access is misaligned for its width

module data_mem_responder #(
    parameter int          DEPTH_WORDS = 256,
    parameter logic [31:0] IO_BASE     = 32'h0000_1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWriteM,
    input  logic [2:0]  Funct3M,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    input  logic [7:0]  gpio_in,
    output logic [31:0] ReadDataM,
    output logic [7:0]  gpio_out,
    output logic        MisalignM
);

    localparam int AW = $clog2(DEPTH_WORDS);

    // RAM storage is intentionally not reset so its contents survive a reset.
    logic [31:0] mem_q [DEPTH_WORDS];

    logic [7:0]  gpio_out_q, gpio_out_d;
    logic [7:0]  sync1_q, sync1_d;
    logic [7:0]  sync2_q, sync2_d;
    logic [31:0] cycle_q, cycle_d;

    logic [AW-1:0] word_idx;
    logic [1:0]    lane;
    logic          is_half;
    logic          is_word;
    logic          misalign;
    logic          ram_hit;
    logic          wr_ok;
    logic [31:0]   ram_word;
    logic [7:0]    sel_byte;
    logic [15:0]   sel_half;
    logic [3:0]    ram_be;
    logic [31:0]   ram_wdata;
    logic [31:0]   read_data;

    // Address decode and alignment
    always_comb begin
        lane     = ALUResultM[1:0];
        word_idx = ALUResultM[AW+1:2];
        // 001 (LH/SH) and 101 (LHU) are the halfword codes
        is_half  = (Funct3M[1:0] == 2'b01);
        is_word  = (Funct3M == 3'b010);
        misalign = (is_half && lane[0]) || (is_word && (lane != 2'b00));
        ram_hit  = (ALUResultM[31:AW+2] == '0);
        // Stores are blocked while reset is held, and when misaligned
        wr_ok    = MemWriteM && reset && !misalign;
    end

    // Load path
    always_comb begin
        ram_word  = mem_q[word_idx];
        sel_byte  = ram_word[{lane, 3'b000} +: 8];
        sel_half  = lane[1] ? ram_word[31:16] : ram_word[15:0];
        read_data = 32'b0;
        if (!misalign) begin
            if (ram_hit) begin
                case (Funct3M)
                    3'b000:  read_data = {{24{sel_byte[7]}}, sel_byte};
                    3'b001:  read_data = {{16{sel_half[15]}}, sel_half};
                    3'b010:  read_data = ram_word;
                    3'b100:  read_data = {24'b0, sel_byte};
                    3'b101:  read_data = {16'b0, sel_half};
                    default: read_data = 32'b0;
                endcase
            end else if (is_word) begin
                // I/O window answers word accesses only
                if (ALUResultM == IO_BASE) begin
                    read_data = {24'b0, gpio_out_q};
                end else if (ALUResultM == IO_BASE + 32'd4) begin
                    read_data = {24'b0, sync2_q};
                end else if (ALUResultM == IO_BASE + 32'd8) begin
                    read_data = cycle_q;
                end
            end
        end
    end

    // Store path: byte enables plus lane-replicated data
    always_comb begin
        ram_be    = 4'b0000;
        ram_wdata = WriteDataM;
        if (wr_ok && ram_hit) begin
            case (Funct3M)
                3'b000: begin
                    ram_be    = 4'b0001 << lane;
                    ram_wdata = {4{WriteDataM[7:0]}};
                end
                3'b001: begin
                    ram_be    = lane[1] ? 4'b1100 : 4'b0011;
                    ram_wdata = {2{WriteDataM[15:0]}};
                end
                3'b010: begin
                    ram_be    = 4'b1111;
                    ram_wdata = WriteDataM;
                end
                default: begin
                    ram_be    = 4'b0000;
                    ram_wdata = WriteDataM;
                end
            endcase
        end
    end

    // Register next-state
    always_comb begin
        gpio_out_d = gpio_out_q;
        if (wr_ok && !ram_hit && is_word && (ALUResultM == IO_BASE)) begin
            gpio_out_d = WriteDataM[7:0];
        end
        sync1_d = gpio_in;
        sync2_d = sync1_q;
        cycle_d = cycle_q + 32'd1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            gpio_out_q <= 8'b0;
            sync1_q    <= 8'b0;
            sync2_q    <= 8'b0;
            cycle_q    <= 32'b0;
        end else begin
            gpio_out_q <= gpio_out_d;
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            cycle_q    <= cycle_d;
        end
    end

    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (ram_be[b]) begin
                mem_q[word_idx][8*b +: 8] <= ram_wdata[8*b +: 8];
            end
        end
    end

    assign ReadDataM = read_data;
    assign gpio_out  = gpio_out_q;
    assign MisalignM = misalign;

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - Self-checking bench for data_mem_responder
module tb_data_mem_responder;

    localparam int          DEPTH = 256;
    localparam logic [31:0] IOB   = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        MemWriteM = 1'b0;
    logic [2:0]  Funct3M = 3'd0;
    logic [31:0] ALUResultM = 32'd0;
    logic [31:0] WriteDataM = 32'd0;
    logic [7:0]  gpio_in = 8'd0;
    logic [31:0] ReadDataM;
    logic [7:0]  gpio_out;
    logic        MisalignM;

    always #5 clk = ~clk;

    data_mem_responder #(.DEPTH_WORDS(DEPTH), .IO_BASE(IOB)) dut (
        .clk        (clk),
        .reset      (reset),
        .MemWriteM  (MemWriteM),
        .Funct3M    (Funct3M),
        .ALUResultM (ALUResultM),
        .WriteDataM (WriteDataM),
        .gpio_in    (gpio_in),
        .ReadDataM  (ReadDataM),
        .gpio_out   (gpio_out),
        .MisalignM  (MisalignM)
    );

    int total = 0;
    int bad   = 0;
    bit check_on = 1'b0;

    // Reference model state
    logic [31:0] mmem [DEPTH];
    logic [7:0]  m_gpio_out = 8'd0;
    logic [7:0]  pin_hist[$];
    logic [31:0] m_cycle = 32'd0;
    int          m_idx;
    int          m_sh;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit exp_mis(input logic [31:0] a, input logic [2:0] f);
        return ((f == 3'd1 || f == 3'd5) && a[0]) || (f == 3'd2 && a[1:0] != 2'b00);
    endfunction

    // Pin value sampled two clock edges ago, zero until two edges have passed
    function automatic logic [7:0] m_gpio_in();
        if (pin_hist.size() >= 2) return pin_hist[pin_hist.size()-2];
        return 8'h00;
    endfunction

    function automatic logic [31:0] exp_read(input logic [31:0] a, input logic [2:0] f);
        logic [31:0] w;
        logic [7:0]  b;
        logic [15:0] h;
        int          sh;
        if (exp_mis(a, f)) return 32'd0;
        if (a < 4 * DEPTH) begin
            w  = mmem[a / 4];
            sh = 8 * int'(a[1:0]);
            b  = w[sh +: 8];
            h  = a[1] ? w[31:16] : w[15:0];
            case (f)
                3'd0: return {{24{b[7]}}, b};
                3'd1: return {{16{h[15]}}, h};
                3'd2: return w;
                3'd4: return {24'h0, b};
                3'd5: return {16'h0, h};
                default: return 32'd0;
            endcase
        end
        if (f != 3'd2) return 32'd0;
        if (a == IOB) return {24'h0, m_gpio_out};
        if (a == IOB + 32'd4) return {24'h0, m_gpio_in()};
        if (a == IOB + 32'd8) return m_cycle;
        return 32'd0;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_gpio_out = 8'd0;
            pin_hist.delete();
            m_cycle = 32'd0;
        end else begin
            if (MemWriteM && !exp_mis(ALUResultM, Funct3M)) begin
                if (ALUResultM < 4 * DEPTH) begin
                    m_idx = int'(ALUResultM / 4);
                    m_sh  = 8 * int'(ALUResultM[1:0]);
                    case (Funct3M)
                        3'd0: mmem[m_idx][m_sh +: 8] = WriteDataM[7:0];
                        3'd1: mmem[m_idx][m_sh +: 16] = WriteDataM[15:0];
                        3'd2: mmem[m_idx] = WriteDataM;
                        default: ;
                    endcase
                end else if (Funct3M == 3'd2 && ALUResultM == IOB) begin
                    m_gpio_out = WriteDataM[7:0];
                end
            end
            pin_hist.push_back(gpio_in);
            if (pin_hist.size() > 2) void'(pin_hist.pop_front());
            m_cycle = m_cycle + 32'd1;
        end
    end

    always @(negedge clk) begin
        #2;
        if (check_on) begin
            chk("rdata", ReadDataM, exp_read(ALUResultM, Funct3M));
            chk("misalign", {31'b0, MisalignM}, {31'b0, exp_mis(ALUResultM, Funct3M)});
            chk("gpio_out", {24'b0, gpio_out}, {24'b0, m_gpio_out});
        end
    end

    task automatic drive(input bit we, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] d);
        @(negedge clk);
        MemWriteM  = we;
        Funct3M    = f;
        ALUResultM = a;
        WriteDataM = d;
    endtask

    task automatic lit(input string nm, input logic [31:0] exp);
        #3;
        chk(nm, ReadDataM, exp);
    endtask

    initial begin
        repeat (3) @(negedge clk);

        // Reset release and cycle counter start
        drive(0, 3'd2, IOB + 32'd8, 32'd0);
        reset    = 1'b1;
        check_on = 1'b1;
        lit("cycle_first", 32'd0);
        chk("gpio_out_reset", {24'b0, gpio_out}, 32'd0);
        repeat (9) @(negedge clk);
        lit("cycle_n10", 32'd9);

        // Fill RAM so every read has a defined value
        check_on = 1'b0;
        for (int i = 0; i < DEPTH; i++) drive(1, 3'd2, 32'(i * 4), $urandom);
        drive(0, 3'd2, 32'd0, 32'd0);
        check_on = 1'b1;

        // Loads of every width
        drive(1, 3'd2, 32'h10, 32'h8765_4321);
        drive(0, 3'd2, 32'h10, 32'd0); lit("lw_10", 32'h8765_4321);
        drive(0, 3'd0, 32'h13, 32'd0); lit("lb_13", 32'hFFFF_FF87);
        drive(0, 3'd4, 32'h13, 32'd0); lit("lbu_13", 32'h0000_0087);
        drive(0, 3'd1, 32'h12, 32'd0); lit("lh_12", 32'hFFFF_8765);

        // Byte store merges into existing word
        drive(1, 3'd0, 32'h11, 32'h0000_00AA);
        drive(0, 3'd2, 32'h10, 32'd0); lit("sb_merge", 32'h8765_AA21);

        // Misaligned store and load
        drive(1, 3'd2, 32'h20, 32'hCAFE_BABE);
        drive(1, 3'd1, 32'h21, 32'h0000_1234);
        #3 chk("mis_sh", {31'b0, MisalignM}, 32'd1);
        drive(0, 3'd2, 32'h22, 32'd0);
        #3 chk("mis_lw", {31'b0, MisalignM}, 32'd1);
        chk("mis_lw_data", ReadDataM, 32'd0);
        drive(0, 3'd2, 32'h20, 32'd0); lit("mis_unchanged", 32'hCAFE_BABE);

        // GPIO output
        drive(1, 3'd2, IOB, 32'h0000_01FF);
        drive(0, 3'd2, IOB, 32'd0);
        #3 chk("gpio_out_ff", {24'b0, gpio_out}, 32'h0000_00FF);
        chk("gpio_out_rd", ReadDataM, 32'h0000_00FF);

        // GPIO input synchronizer latency
        drive(0, 3'd2, IOB + 32'd4, 32'd0);
        gpio_in = 8'h5A;
        lit("gpio_in_c0", 32'd0);
        drive(0, 3'd2, IOB + 32'd4, 32'd0); lit("gpio_in_c1", 32'd0);
        drive(0, 3'd2, IOB + 32'd4, 32'd0); lit("gpio_in_c2", 32'h0000_005A);

        // Reset pulse mid-run
        drive(0, 3'd2, IOB + 32'd8, 32'd0);
        reset = 1'b0;
        lit("rst_cycle", 32'd0);
        chk("rst_gpio_out", {24'b0, gpio_out}, 32'd0);
        drive(1, 3'd2, 32'h10, 32'hDEAD_BEEF);
        drive(0, 3'd2, 32'h10, 32'd0);
        reset = 1'b1;
        lit("rst_ram_keep", 32'h8765_AA21);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] a;
            int r;
            r = $urandom_range(0, 9);
            if (r <= 4)      a = 32'($urandom_range(0, 63));
            else if (r == 5) a = 32'($urandom_range(0, 4 * DEPTH - 1));
            else if (r <= 7) a = IOB + 32'($urandom_range(0, 11));
            else if (r == 8) a = IOB + 32'd12 + 32'($urandom_range(0, 4000));
            else             a = $urandom;
            drive($urandom_range(0, 2) == 0, 3'($urandom_range(0, 7)), a, $urandom);
            if ($urandom_range(0, 7) == 0) gpio_in = 8'($urandom);
            reset = ((i % 500) == 250) ? 1'b0 : 1'b1;
        end

        @(negedge clk);
        #3;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
